// File: rtl/seq_slice_adder.sv
// -----------------------------------------------------------------------------
// seq_slice_adder
//
// Purpose:
//   A multi-cycle ripple-carry adder. It adds two WIDTH-bit operands SLICE bits
//   per clock and keeps the inter-slice carry in a register. Operands arrive on
//   a valid/ready handshake. The result (sum, carry-out, signed overflow) leaves
//   on a second valid/ready handshake. It sits between the operand capture logic
//   and the result display.
//
// Parameters:
//   WIDTH  operand and sum width. Must be a multiple of SLICE.
//   SLICE  bits added per clock. NSLICE = WIDTH/SLICE must be at least 1.
//
// Optional feature (compile-time macro):
//   SEQ_ADD_SUB_EN  When defined, the port `sub` exists and is latched with
//                   the operands. With sub=1 the block computes a - b - cin by
//                   adding ~b with carry-in ~cin. In that case cout=1 means
//                   "no borrow". When undefined, the block only adds.
//
// Ports:
//   Clock      in   1      system clock, rising edge
//   Resetn     in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in to bit 0
//   sub        in   1      (SEQ_ADD_SUB_EN only) 1 = subtract
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of the MSB
//   ovf        out  1      signed overflow (carry into MSB XOR cout)
//   busy       out  1      high in RUN or DONE
//
// Timing:
//   If operands are accepted on edge k, out_valid rises after edge k+NSLICE.
//   The block returns to IDLE on the output handshake edge. It does not accept
//   new operands on that same edge, so one result takes at least NSLICE+2 cycles.
// -----------------------------------------------------------------------------
module seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  // A 1-bit index is used even when NSLICE == 1, so the index register always
  // has a legal width.
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;        // effective B: already inverted when subtracting
  logic              carry_q;    // carry into the slice at idx_q
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_d;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              in_ready_q;

  // ---------------------------------------------------------------------------
  // Operand conditioning at capture time.
  // Subtraction is folded into the latched operands. The slice datapath
  // therefore only ever adds.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef SEQ_ADD_SUB_EN
  always_comb begin
    b_eff   = sub ? ~b   : b;
    cin_eff = sub ? ~cin : cin;
  end
`else
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
  end
`endif

  // ---------------------------------------------------------------------------
  // Slice views of the latched operands.
  // ---------------------------------------------------------------------------
  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // One slice adder, shared across all slices in time.
  // ---------------------------------------------------------------------------
  logic [SLICE-1:0] a_cur;
  logic [SLICE-1:0] b_cur;
  logic [SLICE:0]   slice_res;   // {slice carry-out, slice sum}
  logic             c_into_msb;
  logic             ovf_d;

  always_comb begin
    a_cur     = a_sl[idx_q];
    b_cur     = b_sl[idx_q];
    slice_res = {1'b0, a_cur} + {1'b0, b_cur} + {{SLICE{1'b0}}, carry_q};
    // The slice sum bit equals a ^ b ^ carry-in at that bit position.
    // Solving for the carry-in recovers the carry into the operand MSB
    // when the last slice is active.
    c_into_msb = a_cur[SLICE-1] ^ b_cur[SLICE-1] ^ slice_res[SLICE-1];
    ovf_d      = c_into_msb ^ slice_res[SLICE];
  end

  // Merge the freshly computed slice into the running sum.
  always_comb begin
    sum_d = sum_q;
    if (state_q == RUN) begin
      sum_d[idx_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs are registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_eff;
            carry_q    <= cin_eff;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_res[SLICE];
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_res[SLICE];
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          // Results are held until the consumer takes them. The return to
          // IDLE deliberately does not also accept new operands.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_slice_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_slice_adder
//
// Directed bench for seq_slice_adder. It uses two instances:
//   u_dut16  WIDTH=16, SLICE=4 (four slices)
//   u_dut8   WIDTH=8,  SLICE=8 (single slice, one-cycle result)
// Inputs are driven and outputs are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_slice_adder;

  logic        Clock = 1'b0;
  logic        Resetn;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [15:0] a, b, sum;
`ifdef SEQ_ADD_SUB_EN
  logic        sub_s;
`endif

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8, busy8;
  logic [7:0]  a8, b8, sum8;
`ifdef SEQ_ADD_SUB_EN
  logic        sub8;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 Clock = ~Clock;

  seq_slice_adder #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
    .sub       (sub_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  seq_slice_adder #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef SEQ_ADD_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8),
    .busy      (busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid on the 16-bit instance. The wait is bounded.
  // Returns the number of falling edges seen after the accept edge.
  task automatic wait_result16(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
  endtask

  // One full transaction on the 16-bit instance.
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic ts,
                       input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    @(negedge Clock);
    check($sformatf("%s_in_ready", tag), in_ready, 1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
`ifdef SEQ_ADD_SUB_EN
    sub_s = ts;
`else
    if (ts) $display("[TB] %s: sub ignored in add-only build", tag);
`endif
    @(negedge Clock);
    // Change the operands after acceptance. The result must not depend on these.
    in_valid = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
`ifdef SEQ_ADD_SUB_EN
    sub_s = ~ts;
`endif
    check($sformatf("%s_busy_run", tag), busy, 1);
    check($sformatf("%s_in_ready_run", tag), in_ready, 0);
    wait_result16(cyc);
    check($sformatf("%s_latency", tag), cyc, 4);
    check($sformatf("%s_sum", tag), sum, es);
    check($sformatf("%s_cout", tag), cout, ec);
    check($sformatf("%s_ovf", tag), ovf, eo);
    out_ready = 1'b1;
    @(negedge Clock);
    out_ready = 1'b0;
    check($sformatf("%s_out_valid_drop", tag), out_valid, 0);
    check($sformatf("%s_busy_idle", tag), busy, 0);
    $display("[TB] %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d", tag, ta, tb_v, tc, sum, cout, ovf);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int bad;
    Resetn = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    sub_s = 1'b0; sub8 = 1'b0;
`endif
    repeat (2) @(negedge Clock);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    Resetn = 1'b1;
    @(negedge Clock);
    check("rst_in_ready", in_ready, 1);
    $display("[TB] reset: outputs cleared, in_ready=%0d", in_ready);

    // All-ones plus one wraps to zero.
    run16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    // Positive overflow.
    run16("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    // Ordinary add with carry-in.
    run16("cin", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    // Negative overflow with carry-out.
    run16("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    // A carry rippling through every slice boundary.
    run16("ripple", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Output back-pressure: the result is held and no new operands are accepted.
    @(negedge Clock);
    a = 16'h00F0; b = 16'h0F0F; cin = 1'b0; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    wait_result16(cyc);
    check("stall_latency", cyc, 4);
    a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check($sformatf("stall%0d_sum", i), sum, 16'h0FFF);
      check($sformatf("stall%0d_cout", i), cout, 0);
      check($sformatf("stall%0d_ovf", i), ovf, 0);
      check($sformatf("stall%0d_out_valid", i), out_valid, 1);
      check($sformatf("stall%0d_in_ready", i), in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge Clock);
    out_ready = 1'b0;
    check("stall_no_accept_busy", busy, 0);
    check("stall_no_accept_ready", in_ready, 1);
    @(negedge Clock);
    in_valid = 1'b0;
    check("stall_next_accept", busy, 1);
    wait_result16(cyc);
    check("stall_next_latency", cyc, 4);
    check("stall_next_sum", sum, 16'h0303);
    out_ready = 1'b1;
    @(negedge Clock);
    out_ready = 1'b0;
    $display("[TB] stall: held 0fff for 3 cycles, next result=%h", sum);

    // Reset while the slice index is 2 aborts the operation.
    @(negedge Clock);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (out_valid !== 1'b0) bad++;
    end
    check("abort_no_result", bad, 0);
    $display("[TB] abort: reset mid-RUN, result discarded");
    run16("after_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef SEQ_ADD_SUB_EN
    run16("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Single-slice instance: the result appears one edge after the accept.
    @(negedge Clock);
    check("w8_in_ready", in_ready8, 1);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
    @(negedge Clock);
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    cyc = 0;
    while (out_valid8 !== 1'b1 && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    check("w8_latency", cyc, 1);
    check("w8_sum", sum8, 8'hFF);
    check("w8_cout", cout8, 1);
    check("w8_ovf", ovf8, 0);
    out_ready8 = 1'b1;
    @(negedge Clock);
    out_ready8 = 1'b0;
    check("w8_out_valid_drop", out_valid8, 0);
    $display("[TB] w8: a=ff b=ff cin=1 -> sum=%h cout=%0d", sum8, cout8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
